uart_rx_demux: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_link_watchdog.sv | 45 ++++
 rtl/uart_rx_demux.sv | 134 +++++++++++++
 tb/tb_uart_rx_demux.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared board-link UART definitions: module codes carried in byte bits [7:6]
// (common to the transmit mux and the receive demux), receive FSM state type,
// and default watchdog sizing.
package uart_pkg;

  // Module codes in bits [7:6] of every link byte
  localparam logic [1:0] CODE_GAME_STATE = 2'b00;
  localparam logic [1:0] CODE_GLOVES     = 2'b01;
  localparam logic [1:0] CODE_SCORE      = 2'b10;
  localparam logic [1:0] CODE_MOUSE      = 2'b11;

  // ~15 ms at 65 MHz; counter must satisfy 2**CNT_W > TIMEOUT_CYCLES
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1_000_000;
  localparam int unsigned DEFAULT_CNT_W          = 20;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } rx_state_t;

  // One-hot update strobe for a module code
  function automatic logic [3:0] code_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/uart_link_watchdog.sv
// Link-loss watchdog for the board-link receiver.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   kick           - a byte was routed this cycle; restarts the count
//   link_up        - registered, 1 while bytes arrive within TIMEOUT_CYCLES
//   timeout_pulse  - combinational strobe, high in the cycle whose closing
//                    edge brings the counter to TIMEOUT_CYCLES (the edge on
//                    which link_up falls); never high while kick is high
module uart_link_watchdog
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic link_up,
  output logic timeout_pulse
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Counter is about to reach the limit and no kick overrides it
  assign timeout_pulse = !kick && (cnt == LIMIT - CNT_W'(1));

  // Idle-cycle counter; saturates at the limit, kick wins over timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      link_up <= 1'b0;
    end else if (kick) begin
      cnt     <= '0;
      link_up <= 1'b1;
    end else if (cnt < LIMIT) begin
      cnt <= cnt + CNT_W'(1);
      if (timeout_pulse) begin
        link_up <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_demux.sv
// Board-link UART receive demultiplexer. Pops bytes from the RX FIFO, routes
// each one by its code in bits [7:6] into one of four mirror registers,
// checks round-robin code order and tracks link liveness.
// Optional build macro: CLEAR_ON_LINK_LOSS_EN - when defined, all mirror
// registers clear to 8'h00 on the edge where link_up falls.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   rx_empty, r_data        - RX FIFO empty flag and head byte
//   rd_uart                 - registered FIFO pop strobe
//   data_game_state_sel     - last byte with code 00
//   data_gloves_control     - last byte with code 01
//   data_score_control      - last byte with code 10
//   data_mouse_control      - last byte with code 11
//   upd                     - one-cycle update strobe, bit i = code i written
//   link_up                 - 1 while bytes arrive within TIMEOUT_CYCLES
//   seq_err_cnt             - saturating count of out-of-order codes
module uart_rx_demux
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] data_game_state_sel,
  output logic [7:0] data_gloves_control,
  output logic [7:0] data_score_control,
  output logic [7:0] data_mouse_control,
  output logic [3:0] upd,
  output logic       link_up,
  output logic [7:0] seq_err_cnt
);

  rx_state_t  state;
  rx_state_t  state_next;
  logic [7:0] byte_q;
  logic [1:0] expected;
  logic [1:0] code;
  logic       capture;
  logic       route;
  logic       timeout_pulse;

  assign code = byte_q[7:6];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one byte per two cycles
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_empty) state_next = ROUTE;
      ROUTE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: capture in IDLE, route/pop in ROUTE
  always_comb begin
    capture = 1'b0;
    route   = 1'b0;
    case (state)
      IDLE:    capture = !rx_empty;
      ROUTE:   route   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pop strobe, byte capture, routing, sequence check
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_uart             <= 1'b0;
      byte_q              <= '0;
      upd                 <= '0;
      expected            <= CODE_GAME_STATE;
      seq_err_cnt         <= '0;
      data_game_state_sel <= '0;
      data_gloves_control <= '0;
      data_score_control  <= '0;
      data_mouse_control  <= '0;
    end else begin
      rd_uart <= capture;
      upd     <= route ? code_onehot(code) : 4'b0000;
      if (capture) begin
        byte_q <= r_data;
      end
      if (route) begin
        // Resync to the received code whether or not it was in order
        expected <= code + 2'd1;
        if ((code != expected) && (seq_err_cnt != 8'hFF)) begin
          seq_err_cnt <= seq_err_cnt + 8'd1;
        end
        case (code)
          CODE_GAME_STATE: data_game_state_sel <= byte_q;
          CODE_GLOVES:     data_gloves_control <= byte_q;
          CODE_SCORE:      data_score_control  <= byte_q;
          CODE_MOUSE:      data_mouse_control  <= byte_q;
          default:         ;
        endcase
      end else if (timeout_pulse) begin
        // Next stream after link loss starts cleanly at code 00
        expected <= CODE_GAME_STATE;
`ifdef CLEAR_ON_LINK_LOSS_EN
        data_game_state_sel <= '0;
        data_gloves_control <= '0;
        data_score_control  <= '0;
        data_mouse_control  <= '0;
`endif
      end
    end
  end

  // Link-loss watchdog, kicked by every routed byte
  uart_link_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .kick          (route),
    .link_up       (link_up),
    .timeout_pulse (timeout_pulse)
  );

endmodule

// File: tb/tb_uart_rx_demux.sv
// Self-checking bench for uart_rx_demux with a queue-based RX FIFO and a
// behavioural mirror/sequence model.
module tb_uart_rx_demux;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [7:0] data_game_state_sel;
  logic [7:0] data_gloves_control;
  logic [7:0] data_score_control;
  logic [7:0] data_mouse_control;
  logic [3:0] upd;
  logic       link_up;
  logic [7:0] seq_err_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo[$];

  // Behavioural model state
  logic [7:0] m_data[4];
  int         m_exp;
  int         m_err;

  wire logic [31:0] dut_vec = {data_mouse_control, data_score_control,
                               data_gloves_control, data_game_state_sel};

  always #5 clk = ~clk;

  uart_rx_demux #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_empty            (rx_empty),
    .r_data              (r_data),
    .rd_uart             (rd_uart),
    .data_game_state_sel (data_game_state_sel),
    .data_gloves_control (data_gloves_control),
    .data_score_control  (data_score_control),
    .data_mouse_control  (data_mouse_control),
    .upd                 (upd),
    .link_up             (link_up),
    .seq_err_cnt         (seq_err_cnt)
  );

  // FIFO pops on an edge where the strobe is high, unless reset wins
  always @(posedge clk) begin
    if (rd_uart && !rst && fifo.size() > 0) void'(fifo.pop_front());
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "time bound");
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
    m_exp = 0;
    m_err = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int c;
    c = int'(b[7:6]);
    if (c != m_exp && m_err < 255) m_err = m_err + 1;
    m_exp = (c + 1) % 4;
    m_data[c] = b;
  endfunction

  function automatic void model_timeout();
    m_exp = 0;
`ifdef CLEAR_ON_LINK_LOSS_EN
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
`endif
  endfunction

  function automatic logic [31:0] model_vec();
    return {m_data[3], m_data[2], m_data[1], m_data[0]};
  endfunction

  task automatic refresh();
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
  endtask

  task automatic tick();
    @(negedge clk);
    refresh();
  endtask

  task automatic wait_upd(output logic [3:0] u, output int lat);
    u   = 4'b0000;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (upd !== 4'b0000) begin
        u   = upd;
        lat = i;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [3:0] u, output int lat);
    fifo.push_back(b);
    refresh();
    wait_upd(u, lat);
    model_byte(b);
  endtask

  task automatic do_reset();
    fifo.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo.delete();
    refresh();
    tick();
    tick();
    model_reset();
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL reset_data: got %h expected %h", dut_vec, model_vec()); end
    tests++; if (upd !== 4'b0000) begin fails++; $display("FAIL reset_upd: got %b expected 0000", upd); end
    tests++; if (rd_uart !== 1'b0) begin fails++; $display("FAIL reset_rd_uart: got %b expected 0", rd_uart); end
    tests++; if (link_up !== 1'b0) begin fails++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
    tests++; if (seq_err_cnt !== 8'h00) begin fails++; $display("FAIL reset_seq_err: got %h expected 00", seq_err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[4];
    int         rd_times[$];
    logic [3:0] upd_log[$];
    int         upd_first;
    logic       prev_rd;
    int         consec;
    bytes[0] = 8'h05; bytes[1] = 8'h4A; bytes[2] = 8'h83; bytes[3] = 8'hC7;
    do_reset();
    for (int i = 0; i < 4; i++) fifo.push_back(bytes[i]);
    refresh();
    prev_rd = 1'b0; consec = 0; upd_first = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rd_uart === 1'b1) begin
        rd_times.push_back(c);
        if (prev_rd) consec++;
      end
      if (upd !== 4'b0000) begin
        upd_log.push_back(upd);
        if (upd_first < 0) upd_first = c;
      end
      prev_rd = (rd_uart === 1'b1);
    end
    for (int i = 0; i < 4; i++) model_byte(bytes[i]);
    tests++; if (rd_times.size() != 4) begin fails++; $display("FAIL b2b_rd_count: got %0d expected 4", rd_times.size()); end
    tests++; if (consec != 0) begin fails++; $display("FAIL b2b_rd_consecutive: got %0d expected 0", consec); end
    for (int i = 1; i < rd_times.size(); i++) begin
      tests++; if (rd_times[i] - rd_times[i-1] != 2) begin fails++; $display("FAIL b2b_rd_spacing: got %0d expected 2", rd_times[i] - rd_times[i-1]); end
    end
    tests++; if (rd_times.size() == 0 || rd_times[0] != 1) begin fails++; $display("FAIL b2b_first_rd: got %0d expected 1", rd_times.size() == 0 ? -1 : rd_times[0]); end
    tests++; if (upd_first != 2) begin fails++; $display("FAIL b2b_latency: got %0d expected 2", upd_first); end
    tests++; if (upd_log.size() != 4) begin fails++; $display("FAIL b2b_upd_count: got %0d expected 4", upd_log.size()); end
    for (int i = 0; i < upd_log.size() && i < 4; i++) begin
      tests++; if (upd_log[i] !== 4'(1 << int'(bytes[i][7:6]))) begin fails++; $display("FAIL b2b_upd_seq: got %b expected %b", upd_log[i], 4'(1 << int'(bytes[i][7:6]))); end
    end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL b2b_data: got %h expected %h", dut_vec, model_vec()); end
    tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL b2b_seq_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
    tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL b2b_link_up: got %b expected 1", link_up); end
  endtask

  task automatic test_skip();
    logic [3:0] u;
    int         lat;
    do_reset();
    send_byte(8'h05, u, lat);
    send_byte(8'h83, u, lat);
    tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL skip_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL skip_data: got %h expected %h", dut_vec, model_vec()); end
    send_byte(8'hC0, u, lat);
    tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL skip_resync_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
    tests++; if (u !== 4'b1000) begin fails++; $display("FAIL skip_upd: got %b expected 1000", u); end
  endtask

  task automatic test_random();
    logic [3:0] u;
    int         lat;
    int         code;
    logic [7:0] b;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      code = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_exp;
      b = {2'(code), 6'($urandom)};
      repeat ($urandom_range(0, 5)) tick();
      send_byte(b, u, lat);
      tests++; if (u !== 4'(1 << code)) begin fails++; $display("FAIL rand_upd: got %b expected %b", u, 4'(1 << code)); end
      tests++; if (lat != 2) begin fails++; $display("FAIL rand_latency: got %0d expected 2", lat); end
      tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL rand_data: got %h expected %h", dut_vec, model_vec()); end
      tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL rand_seq_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
      tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL rand_link_up: got %b expected 1", link_up); end
    end
  endtask

  task automatic test_idle();
    int rd_seen;
    int upd_seen;
    rd_seen = 0; upd_seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (rd_uart !== 1'b0) rd_seen++;
      if (upd !== 4'b0000) upd_seen++;
    end
    tests++; if (rd_seen != 0) begin fails++; $display("FAIL idle_rd: got %0d expected 0", rd_seen); end
    tests++; if (upd_seen != 0) begin fails++; $display("FAIL idle_upd: got %0d expected 0", upd_seen); end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL idle_data: got %h expected %h", dut_vec, model_vec()); end
    tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL idle_seq_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
    tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL idle_link_up: got %b expected 1", link_up); end
  endtask

  task automatic test_saturate();
    logic [3:0] u;
    int         lat;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      send_byte({2'b00, 6'($urandom)}, u, lat);
      if (n == 200) begin
        tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL sat_mid: got %h expected %h", seq_err_cnt, 8'(m_err)); end
      end
    end
    tests++; if (seq_err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_final: got %h expected ff", seq_err_cnt); end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL sat_data: got %h expected %h", dut_vec, model_vec()); end
  endtask

  task automatic test_timeout();
    logic [3:0] u;
    int         lat;
    int         n;
    do_reset();
    send_byte(8'h05, u, lat);
    tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL to_link_before: got %b expected 1", link_up); end
    n = 0;
    for (int c = 1; c <= 150; c++) begin
      tick();
      if (link_up === 1'b0) begin
        n = c;
        break;
      end
    end
    model_timeout();
    tests++; if (n != int'(TO)) begin fails++; $display("FAIL to_fall_cycle: got %0d expected %0d", n, TO); end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL to_data_after: got %h expected %h", dut_vec, model_vec()); end
    tests++; if (upd !== 4'b0000) begin fails++; $display("FAIL to_upd: got %b expected 0000", upd); end
    send_byte(8'h4A, u, lat);
    tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL to_seq_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
    tests++; if (link_up !== 1'b1) begin fails++; $display("FAIL to_link_after: got %b expected 1", link_up); end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL to_data_new: got %h expected %h", dut_vec, model_vec()); end
  endtask

  task automatic test_reset_in_route();
    logic [3:0] u;
    int         lat;
    do_reset();
    fifo.push_back(8'h83);
    refresh();
    tick();
    tests++; if (rd_uart !== 1'b1) begin fails++; $display("FAIL rir_rd_before: got %b expected 1", rd_uart); end
    rst = 1'b1;
    tick();
    model_reset();
    tests++; if (rd_uart !== 1'b0) begin fails++; $display("FAIL rir_rd_at_reset: got %b expected 0", rd_uart); end
    tests++; if (upd !== 4'b0000) begin fails++; $display("FAIL rir_upd_at_reset: got %b expected 0000", upd); end
    rst = 1'b0;
    wait_upd(u, lat);
    model_byte(8'h83);
    tests++; if (u !== 4'b0100) begin fails++; $display("FAIL rir_upd_reread: got %b expected 0100", u); end
    tests++; if (dut_vec !== model_vec()) begin fails++; $display("FAIL rir_data: got %h expected %h", dut_vec, model_vec()); end
    tests++; if (seq_err_cnt !== 8'(m_err)) begin fails++; $display("FAIL rir_seq_err: got %h expected %h", seq_err_cnt, 8'(m_err)); end
  endtask

  initial begin
    rst      = 1'b1;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    model_reset();
    test_reset();
    test_back_to_back();
    test_skip();
    test_random();
    test_idle();
    test_saturate();
    test_timeout();
    test_reset_in_route();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
